// File: rtl/mem_stage.sv
// Memory stage: issues one dcache access per load/store and stalls until dhit; ALU ops pass in 1 cycle.
// Result strobes wben one cycle after completion; in_ready drops while an access is outstanding or after halt.
module mem_stage #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_memRd,
  input  logic              in_memWr,
  input  logic              in_regWr,
  input  logic [REG_W-1:0]  in_regDst,
  input  logic [1:0]        in_regSel,
  input  logic [WORD_W-1:0] in_ALUOut,
  input  logic [WORD_W-1:0] in_storeData,
  input  logic [WORD_W-1:0] in_nPC,
  input  logic [WORD_W-1:0] in_lui,
  input  logic              in_halt,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  output logic              wben,
  output logic              wb_regWr,
  output logic [REG_W-1:0]  wb_regDst,
  output logic [1:0]        wb_regSel,
  output logic [WORD_W-1:0] wb_ALUOut,
  output logic [WORD_W-1:0] wb_nPC,
  output logic [WORD_W-1:0] wb_lui,
  output logic [WORD_W-1:0] wb_dmemload,
  output logic              mem_stall,
  output logic              halt,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam logic [1:0] EMPTY    = 2'd0;
  localparam logic [1:0] ACCESS   = 2'd1;
  localparam logic [1:0] COMPLETE = 2'd2;

  logic [1:0]        state, state_nxt;
  logic              op_memRd, op_memWr, op_halt;
  logic [WORD_W-1:0] op_storeData;
  logic              accept;
  logic              in_access;
  logic [1:0]        accept_state;

  assign in_access = (state == ACCESS);
  // A completing halt must not let a younger instruction slip in behind it.
  assign in_ready  = ~halt & ((state == EMPTY) | ((state == COMPLETE) & ~op_halt));
  assign accept    = in_valid & in_ready;
  assign accept_state = (in_memRd | in_memWr) ? ACCESS : COMPLETE;

  assign wben      = (state == COMPLETE);
  assign mem_stall = in_access;
  assign dmemREN   = in_access & op_memRd;
  assign dmemWEN   = in_access & op_memWr & ~op_memRd;
  assign dmemaddr  = in_access ? wb_ALUOut : '0;
  assign dmemstore = in_access ? op_storeData : '0;

  always_comb begin
    state_nxt = EMPTY;
    case (state)
      EMPTY:    state_nxt = accept ? accept_state : EMPTY;
      ACCESS:   state_nxt = dhit ? COMPLETE : ACCESS;
      COMPLETE: state_nxt = (!op_halt && accept) ? accept_state : EMPTY;
      default:  state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= EMPTY;
      op_memRd     <= 1'b0;
      op_memWr     <= 1'b0;
      op_halt      <= 1'b0;
      op_storeData <= '0;
      wb_regWr     <= 1'b0;
      wb_regDst    <= '0;
      wb_regSel    <= '0;
      wb_ALUOut    <= '0;
      wb_nPC       <= '0;
      wb_lui       <= '0;
      wb_dmemload  <= '0;
      halt         <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_memRd     <= in_memRd;
        op_memWr     <= in_memWr;
        op_halt      <= in_halt;
        op_storeData <= in_storeData;
        wb_regWr     <= in_regWr;
        wb_regDst    <= in_regDst;
        wb_regSel    <= in_regSel;
        wb_ALUOut    <= in_ALUOut;
        wb_nPC       <= in_nPC;
        wb_lui       <= in_lui;
      end
      if (in_access) begin
        if (stall_cycles != {CNT_W{1'b1}})
          stall_cycles <= stall_cycles + 1'b1;
        if (dhit && op_memRd)
          wb_dmemload <= dmemload;
      end
      if (state == COMPLETE && op_halt)
        halt <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage against a transaction-level reference model.
module tb_mem_stage;
  localparam int W = 32;
  localparam int R = 5;
  localparam int C = 5;
  localparam int SMAX = (1 << C) - 1;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         in_valid = 1'b0, in_ready;
  logic         in_memRd = 1'b0, in_memWr = 1'b0, in_regWr = 1'b0, in_halt = 1'b0;
  logic [R-1:0] in_regDst = '0;
  logic [1:0]   in_regSel = '0;
  logic [W-1:0] in_ALUOut = '0, in_storeData = '0, in_nPC = '0, in_lui = '0;
  logic         dmemREN, dmemWEN, dhit = 1'b0;
  logic [W-1:0] dmemaddr, dmemstore, dmemload = '0;
  logic         wben, wb_regWr, mem_stall, halt;
  logic [R-1:0] wb_regDst;
  logic [1:0]   wb_regSel;
  logic [W-1:0] wb_ALUOut, wb_nPC, wb_lui, wb_dmemload;
  logic [C-1:0] stall_cycles;

  always #5 CLK = ~CLK;

  mem_stage #(.WORD_W(W), .REG_W(R), .CNT_W(C)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .in_memRd(in_memRd), .in_memWr(in_memWr), .in_regWr(in_regWr),
    .in_regDst(in_regDst), .in_regSel(in_regSel), .in_ALUOut(in_ALUOut),
    .in_storeData(in_storeData), .in_nPC(in_nPC), .in_lui(in_lui),
    .in_halt(in_halt), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dhit(dhit),
    .dmemload(dmemload), .wben(wben), .wb_regWr(wb_regWr),
    .wb_regDst(wb_regDst), .wb_regSel(wb_regSel), .wb_ALUOut(wb_ALUOut),
    .wb_nPC(wb_nPC), .wb_lui(wb_lui), .wb_dmemload(wb_dmemload),
    .mem_stall(mem_stall), .halt(halt), .stall_cycles(stall_cycles)
  );

  typedef struct packed {
    logic         rd;
    logic         wr;
    logic         rw;
    logic [R-1:0] dst;
    logic [1:0]   sel;
    logic [W-1:0] alu;
    logic [W-1:0] sd;
    logic [W-1:0] npc;
    logic [W-1:0] lui;
    logic         hlt;
  } ins_t;

  // Reference model: the instruction in flight, whether it still awaits the
  // cache, whether its result is being handed to write-back this cycle.
  ins_t         cur;
  bit           waiting, wb_now, halted;
  int           stall;
  logic [W-1:0] ld;
  int           total = 0, bad = 0, cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit exp_ready();
    if (waiting) return 1'b0;
    if (wb_now)  return !halted && !cur.hlt;
    return !halted;
  endfunction

  task automatic check_all();
    check("in_ready",  64'(in_ready),  64'(exp_ready()));
    check("wben",      64'(wben),      64'(wb_now));
    check("mem_stall", 64'(mem_stall), 64'(waiting));
    check("dmemREN",   64'(dmemREN),   64'(waiting && cur.rd));
    check("dmemWEN",   64'(dmemWEN),   64'(waiting && cur.wr && !cur.rd));
    if (waiting) begin
      check("dmemaddr",  64'(dmemaddr),  64'(cur.alu));
      check("dmemstore", 64'(dmemstore), 64'(cur.sd));
    end
    check("halt",         64'(halt),         64'(halted));
    check("stall_cycles", 64'(stall_cycles), 64'(stall));
    check("wb_regWr",     64'(wb_regWr),     64'(cur.rw));
    check("wb_regDst",    64'(wb_regDst),    64'(cur.dst));
    check("wb_regSel",    64'(wb_regSel),    64'(cur.sel));
    check("wb_ALUOut",    64'(wb_ALUOut),    64'(cur.alu));
    check("wb_nPC",       64'(wb_nPC),       64'(cur.npc));
    check("wb_lui",       64'(wb_lui),       64'(cur.lui));
    check("wb_dmemload",  64'(wb_dmemload),  64'(ld));
  endtask

  task automatic step(input bit rst, input bit v, input ins_t i, input bit dh, input logic [W-1:0] dl);
    bit acc;
    @(negedge CLK);
    RST = rst; in_valid = v; dhit = dh; dmemload = dl;
    in_memRd = i.rd; in_memWr = i.wr; in_regWr = i.rw; in_regDst = i.dst;
    in_regSel = i.sel; in_ALUOut = i.alu; in_storeData = i.sd;
    in_nPC = i.npc; in_lui = i.lui; in_halt = i.hlt;
    acc = v && exp_ready();
    if (rst) begin
      waiting = 0; wb_now = 0; halted = 0; stall = 0; ld = '0; cur = '0;
    end else if (waiting) begin
      if (stall < SMAX) stall++;
      if (dh) begin
        if (cur.rd) ld = dl;
        waiting = 0;
        wb_now = 1;
      end
    end else begin
      if (wb_now && cur.hlt) halted = 1;
      wb_now = 0;
      if (acc) begin
        cur = i;
        if (i.rd || i.wr) waiting = 1;
        else wb_now = 1;
      end
    end
    @(posedge CLK);
    #1;
    cyc++;
    check_all();
  endtask

  function automatic ins_t mk(input bit rd, input bit wr, input bit hlt,
                              input logic [W-1:0] alu, input logic [W-1:0] sd);
    ins_t i;
    i.rd = rd; i.wr = wr; i.hlt = hlt; i.alu = alu; i.sd = sd;
    i.rw = !wr; i.dst = R'($urandom); i.sel = rd ? 2'd3 : 2'd0;
    i.npc = $urandom; i.lui = $urandom;
    return i;
  endfunction

  function automatic ins_t rnd();
    ins_t i;
    i.rd  = ($urandom_range(0, 9) < 3);
    i.wr  = ($urandom_range(0, 9) < 2);
    i.rw  = 1'($urandom);
    i.dst = R'($urandom);
    i.sel = 2'($urandom);
    i.alu = $urandom; i.sd = $urandom; i.npc = $urandom; i.lui = $urandom;
    i.hlt = ($urandom_range(0, 59) == 0);
    return i;
  endfunction

  ins_t nop;

  initial begin
    nop = '0;
    waiting = 0; wb_now = 0; halted = 0; stall = 0; ld = '0; cur = '0;

    step(1, 0, nop, 0, '0);
    step(1, 1, rnd(), 1, 32'h1234);

    // Back-to-back ALU ops.
    step(0, 1, mk(0, 0, 0, 32'h10, 0), 0, '0);
    step(0, 1, mk(0, 0, 0, 32'h20, 0), 0, '0);
    check("alu2_wben", 64'(wben), 64'd1);
    check("alu2_out",  64'(wb_ALUOut), 64'h20);
    step(0, 0, nop, 0, '0);

    // Load with dhit three cycles after accept.
    step(0, 1, mk(1, 0, 0, 32'h100, 0), 0, '0);
    step(0, 0, nop, 0, '0);
    step(0, 0, nop, 0, '0);
    step(0, 0, nop, 1, 32'hDEADBEEF);
    check("load_wben",   64'(wben), 64'd1);
    check("load_data",   64'(wb_dmemload), 64'hDEADBEEF);
    check("load_stalls", 64'(stall_cycles), 64'd3);
    step(0, 0, nop, 1, 32'h0BAD0BAD);

    // Store with immediate dhit, then a read+write combined op.
    step(0, 1, mk(0, 1, 0, 32'h200, 32'h55), 0, '0);
    step(0, 0, nop, 1, 32'h77777777);
    check("store_keeps_load", 64'(wb_dmemload), 64'hDEADBEEF);
    step(0, 1, mk(1, 1, 0, 32'h300, 32'h66), 0, '0);
    step(0, 0, nop, 1, 32'hCAFEF00D);
    step(0, 0, nop, 0, '0);

    // Reset mid-access, then a normal ALU op.
    step(0, 1, mk(1, 0, 0, 32'h400, 0), 0, '0);
    step(0, 0, nop, 0, '0);
    step(1, 0, nop, 0, '0);
    step(0, 1, mk(0, 0, 0, 32'h44, 0), 0, '0);
    step(0, 0, nop, 0, '0);

    // Halt followed by a steady stream of valid ALU ops.
    step(0, 1, mk(0, 0, 1, 32'h50, 0), 0, '0);
    for (int k = 0; k < 5; k++) step(0, 1, mk(0, 0, 0, 32'h60 + k, 0), 0, '0);
    check("halt_sticky", 64'(halt), 64'd1);
    step(1, 0, nop, 0, '0);

    // Random traffic with occasional resets, including mid-access.
    for (int n = 0; n < 3000; n++) begin
      bit r;
      r = halted ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 199) == 0);
      step(r, ($urandom_range(0, 9) < 7), rnd(), ($urandom_range(0, 9) < 4), $urandom);
    end

    // Counter saturation.
    step(1, 0, nop, 0, '0);
    step(0, 1, mk(1, 0, 0, 32'h500, 0), 0, '0);
    for (int k = 0; k < SMAX + 4; k++) step(0, 0, nop, 0, '0);
    check("stall_sat", 64'(stall_cycles), 64'(SMAX));
    step(0, 0, nop, 1, 32'h12345678);
    step(0, 0, nop, 0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
